// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Outputs are registered and update on the same edge as the counters.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2,
  parameter int   COORD_W  = 11,
  parameter int   FRAME_W  = 16
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  output logic               pix_en,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               ativo_vga,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int HE      = HW + 1;
  localparam int VE      = VW + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_nxt;
  logic          step;
  logic [HE-1:0] hh;
  logic [VE-1:0] vv;
  logic          h_in;
  logic          v_in;
  logic          hs_n;
  logic          vs_n;
  logic          sol;
  logic          sof;
  logic [COORD_W-1:0] x_n;
  logic [COORD_W-1:0] y_n;

  assign step       = enable && (div_cnt == DIV_LAST);
  assign pix_en     = step;
  assign VGA_CLK    = (div_cnt >= DIV_HALF);
  assign VGA_SYNC_N = 1'b1;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (step) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_nxt = h_cnt + HW'(1);
      end
    end
  end

  // Widened by one bit so window ends equal to the total cannot alias.
  assign hh   = {1'b0, h_nxt};
  assign vv   = {1'b0, v_nxt};
  assign h_in = (hh >= HE'(HA0)) && (hh < HE'(HA0 + H_ACTIVE));
  assign v_in = (vv >= VE'(VA0)) && (vv < VE'(VA0 + V_ACTIVE));
  assign hs_n = (hh < HE'(H_SYNC)) ? HS_POL : ~HS_POL;
  assign vs_n = (vv < VE'(V_SYNC)) ? VS_POL : ~VS_POL;
  assign x_n  = h_in ? COORD_W'(h_nxt - HW'(HA0)) : '0;
  assign y_n  = v_in ? COORD_W'(v_nxt - VW'(VA0)) : '0;
  assign sol  = (h_nxt == '0);
  assign sof  = sol && (v_nxt == '0);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      ativo_vga   <= 1'b0;
      VGA_BLANK_N <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        div_cnt <= step ? '0 : div_cnt + DW'(1);
      end
      if (step) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        VGA_HS      <= hs_n;
        VGA_VS      <= vs_n;
        ativo_vga   <= h_in && v_in;
        VGA_BLANK_N <= h_in && v_in;
        x           <= x_n;
        y           <= y_n;
        line_start  <= sol;
        frame_start <= sof;
        if (sof) begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default and small parameter sets.
// Expected pixel records are queued up front and popped by monitors.
module tb_vga_timing_gen;

  typedef struct {
    int p;
    int hs;
    int vs;
    int act;
    int x;
    int y;
    int ls;
    int fs;
    int fc;
    int gap;
    int vh;
  } exp_t;

  logic clk;
  logic rst_d;
  logic rst_s;
  logic en_d;
  logic en_s;

  logic        d_pix_en, d_vclk, d_hs, d_vs, d_blank, d_sync, d_act;
  logic [10:0] d_x, d_y;
  logic        d_ls, d_fs;
  logic [15:0] d_fc;

  logic        s_pix_en, s_vclk, s_hs, s_vs, s_blank, s_sync, s_act;
  logic [10:0] s_x, s_y;
  logic        s_ls, s_fs;
  logic [3:0]  s_fc;

  int checks;
  int failures;

  exp_t qd[$];
  exp_t qs[$];
  exp_t ed;
  exp_t es;

  int       d_idx, d_cyc, d_last, d_gap;
  logic     d_pe;
  logic [3:0] d_hist;
  int       s_idx, s_cyc, s_last, s_gap;
  logic     s_pe;
  logic [3:0] s_hist;

  vga_timing_gen u_d (
    .CLOCK_50    (clk),
    .reset       (rst_d),
    .enable      (en_d),
    .pix_en      (d_pix_en),
    .VGA_CLK     (d_vclk),
    .VGA_HS      (d_hs),
    .VGA_VS      (d_vs),
    .VGA_BLANK_N (d_blank),
    .VGA_SYNC_N  (d_sync),
    .ativo_vga   (d_act),
    .x           (d_x),
    .y           (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_cnt   (d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1),
    .CLK_DIV  (4),
    .COORD_W  (11),
    .FRAME_W  (4)
  ) u_s (
    .CLOCK_50    (clk),
    .reset       (rst_s),
    .enable      (en_s),
    .pix_en      (s_pix_en),
    .VGA_CLK     (s_vclk),
    .VGA_HS      (s_hs),
    .VGA_VS      (s_vs),
    .VGA_BLANK_N (s_blank),
    .VGA_SYNC_N  (s_sync),
    .ativo_vga   (s_act),
    .x           (s_x),
    .y           (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_cnt   (s_fc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
    end
  endtask

  function automatic exp_t mk(input int p, hs, vs, act, x, y,
                              ls, fs, fc, gap, vh);
    exp_t e;
    e.p = p; e.hs = hs; e.vs = vs; e.act = act; e.x = x; e.y = y;
    e.ls = ls; e.fs = fs; e.fc = fc; e.gap = gap; e.vh = vh;
    return e;
  endfunction

  task automatic cmp(input string t, input exp_t e,
                     input int hs, vs, act, blk, x, y,
                     input int ls, fs, fc, gap, vh);
    string n;
    n = $sformatf("%s_p%0d", t, e.p);
    chk({n, "_hs"}, hs, e.hs);
    chk({n, "_vs"}, vs, e.vs);
    chk({n, "_act"}, act, e.act);
    chk({n, "_blank"}, blk, e.act);
    chk({n, "_x"}, x, e.x);
    chk({n, "_y"}, y, e.y);
    chk({n, "_ls"}, ls, e.ls);
    chk({n, "_fs"}, fs, e.fs);
    chk({n, "_fc"}, fc, e.fc);
    chk({n, "_gap"}, gap, e.gap);
    chk({n, "_vclk"}, vh, e.vh);
  endtask

  // A pixel is presented in the cycle after its pix_en strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_d) begin
        d_idx = 0; d_cyc = 0; d_last = -1; d_gap = -1;
        d_pe = 1'b0; d_hist = '0;
      end else begin
        d_cyc++;
        d_hist = {d_hist[2:0], d_vclk};
        if (d_pe) begin
          if (qd.size() > 0 && qd[0].p == d_idx) begin
            ed = qd.pop_front();
            cmp("d", ed, int'(d_hs), int'(d_vs), int'(d_act),
                int'(d_blank), int'(d_x), int'(d_y), int'(d_ls),
                int'(d_fs), int'(d_fc), d_gap, int'(d_hist));
          end
          d_idx++;
        end
        d_pe = d_pix_en;
        if (d_pix_en) begin
          d_gap  = (d_last < 0) ? -1 : d_cyc - d_last;
          d_last = d_cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_s) begin
        s_idx = 0; s_cyc = 0; s_last = -1; s_gap = -1;
        s_pe = 1'b0; s_hist = '0;
      end else begin
        s_cyc++;
        s_hist = {s_hist[2:0], s_vclk};
        if (s_pe) begin
          if (qs.size() > 0 && qs[0].p == s_idx) begin
            es = qs.pop_front();
            cmp("s", es, int'(s_hs), int'(s_vs), int'(s_act),
                int'(s_blank), int'(s_x), int'(s_y), int'(s_ls),
                int'(s_fs), int'(s_fc), s_gap, int'(s_hist));
          end
          s_idx++;
        end
        s_pe = s_pix_en;
        if (s_pix_en) begin
          s_gap  = (s_last < 0) ? -1 : s_cyc - s_last;
          s_last = s_cyc;
        end
      end
    end
  end

  task automatic check_reset_d(input string t);
    chk({t, "_hs"}, int'(d_hs), 1);
    chk({t, "_vs"}, int'(d_vs), 1);
    chk({t, "_act"}, int'(d_act), 0);
    chk({t, "_blank"}, int'(d_blank), 0);
    chk({t, "_x"}, int'(d_x), 0);
    chk({t, "_y"}, int'(d_y), 0);
    chk({t, "_pix_en"}, int'(d_pix_en), 0);
    chk({t, "_ls"}, int'(d_ls), 0);
    chk({t, "_fs"}, int'(d_fs), 0);
    chk({t, "_fc"}, int'(d_fc), 0);
    chk({t, "_vclk"}, int'(d_vclk), 0);
  endtask

  task automatic push_first_d();
    qd.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, -1, -1));
    qd.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, -1));
    qd.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 10));
  endtask

  task automatic drain(input int limit, input string t);
    int n;
    n = 0;
    while ((qd.size() + qs.size()) != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(t, qd.size() + qs.size(), 0);
  endtask

  initial begin
    int n;
    int bad;
    checks   = 0;
    failures = 0;
    rst_d = 1'b1;
    rst_s = 1'b1;
    en_d  = 1'b1;
    en_s  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_d("rst0_d");
    chk("sync_n_d", int'(d_sync), 1);
    chk("rst0_s_hs", int'(s_hs), 0);
    chk("rst0_s_vs", int'(s_vs), 0);
    chk("rst0_s_fc", int'(s_fc), 0);

    // Defaults: hs low for h 0..95, active h 144..783, lines 35..514.
    push_first_d();
    qd.push_back(mk(95,    0, 0, 0, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(96,    1, 0, 0, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(145,   1, 0, 0, 1,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(783,   1, 0, 0, 639, 0, 0, 0, 1, 2, 10));
    qd.push_back(mk(784,   1, 0, 0, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(800,   0, 0, 0, 0,   0, 1, 0, 1, 2, 10));
    qd.push_back(mk(801,   0, 0, 0, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(1600,  0, 1, 0, 0,   0, 1, 0, 1, 2, 10));
    qd.push_back(mk(28143, 1, 1, 0, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(28144, 1, 1, 1, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(28244, 1, 1, 1, 100, 0, 0, 0, 1, 2, 10));
    qd.push_back(mk(28245, 1, 1, 1, 101, 0, 0, 0, 1, -1, -1));
    qd.push_back(mk(28783, 1, 1, 1, 639, 0, 0, 0, 1, 2, 10));
    qd.push_back(mk(28784, 1, 1, 0, 0,   0, 0, 0, 1, 2, 10));
    qd.push_back(mk(28800, 0, 1, 0, 0,   1, 1, 0, 1, 2, 10));
    qd.push_back(mk(28944, 1, 1, 1, 0,   1, 0, 0, 1, 2, 10));

    // Small: 12 pixels x 7 lines, active h 3..10, v 2..5, 84 px/frame.
    qs.push_back(mk(0,    1, 1, 0, 0, 0, 1, 1, 1,  -1, -1));
    qs.push_back(mk(1,    1, 1, 0, 0, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(2,    0, 1, 0, 0, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(4,    0, 1, 0, 1, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(12,   1, 0, 0, 0, 0, 1, 0, 1,  4, 6));
    qs.push_back(mk(27,   0, 0, 1, 0, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(34,   0, 0, 1, 7, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(35,   0, 0, 0, 0, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(36,   1, 0, 0, 0, 1, 1, 0, 1,  4, 6));
    qs.push_back(mk(70,   0, 0, 1, 7, 3, 0, 0, 1,  4, 6));
    qs.push_back(mk(79,   0, 0, 0, 4, 0, 0, 0, 1,  4, 6));
    qs.push_back(mk(84,   1, 1, 0, 0, 0, 1, 1, 2,  4, 6));
    qs.push_back(mk(85,   1, 1, 0, 0, 0, 0, 0, 2,  4, 6));
    qs.push_back(mk(1176, 1, 1, 0, 0, 0, 1, 1, 15, 4, 6));
    qs.push_back(mk(1260, 1, 1, 0, 0, 0, 1, 1, 0,  4, 6));
    qs.push_back(mk(1344, 1, 1, 0, 0, 0, 1, 1, 1,  4, 6));

    rst_d = 1'b0;
    rst_s = 1'b0;

    n = 0;
    while (d_idx < 28245 && n < 70000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_freeze", d_idx, 28245);

    // Freeze at x=100 on the first active line.
    en_d = 1'b0;
    bad  = 0;
    repeat (37) begin
      @(negedge clk);
      #1;
      if (d_pix_en || d_ls || d_fs || d_vclk || d_x != 11'd100 ||
          !d_act || !d_blank || d_y != 11'd0 || !d_hs || !d_vs ||
          d_fc != 16'd1)
        bad++;
    end
    chk("freeze_bad_cycles", bad, 0);
    chk("freeze_x", int'(d_x), 100);
    en_d = 1'b1;

    drain(40000, "drain_main");

    @(posedge clk);
    #3;
    rst_d = 1'b1;
    #1;
    check_reset_d("async_rst");
    push_first_d();
    repeat (3) @(negedge clk);
    #1;
    rst_d = 1'b0;
    drain(200, "drain_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. It is the next generation of the team's fixed 640x480 sync block.
- Derives a pixel enable and pixel clock from CLOCK_50 using an integer divider.
- Drives HSYNC/VSYNC with configurable porches and polarity, and outputs active-region pixel coordinates.
- Emits line/frame strobes and a frame counter for downstream pixel generators such as sprite or framebuffer readers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- HS_POL, 0, asserted level of VGA_HS
- VS_POL, 0, asserted level of VGA_VS
- CLK_DIV, 2, CLOCK_50 cycles per pixel; must be >= 2
- COORD_W, 11, width of the coordinate outputs
- FRAME_W, 16, width of the frame counter

Ports:
- CLOCK_50, in, 1: system clock
- reset, in, 1: asynchronous, active-high reset
- enable, in, 1: timing advances only while high
- pix_en, out, 1: one-CLOCK_50-cycle strobe marking each pixel step
- VGA_CLK, out, 1: pixel clock to the DAC
- VGA_HS, out, 1: horizontal sync
- VGA_VS, out, 1: vertical sync
- VGA_BLANK_N, out, 1: low outside the active region
- VGA_SYNC_N, out, 1: tied to 1
- ativo_vga, out, 1: high inside the active region
- x, out, COORD_W: active column, 0..H_ACTIVE-1
- y, out, COORD_W: active row, 0..V_ACTIVE-1
- line_start, out, 1: strobe marking the start of every line
- frame_start, out, 1: strobe marking the start of every frame
- frame_cnt, out, FRAME_W: count of completed frames

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP
  - V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP
  - HA0 = H_SYNC + H_BP
  - VA0 = V_SYNC + V_BP
- Segment order on both axes: sync, back porch, active, front porch. Counter value 0 is the first sync pixel/line.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 while enable is high, then wraps.
  - pix_en is high only when div_cnt == CLK_DIV-1 and enable is high.
  - VGA_CLK = (div_cnt >= CLK_DIV/2). Its rising edge falls mid-pixel, and it is a 50% duty square wave when CLK_DIV is even.
- enable low: div_cnt, h_cnt, v_cnt and all outputs hold their values; pix_en and the strobes stay 0.
- Counters:
  - On pix_en, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0.
- Output registers:
  - All outputs except VGA_SYNC_N and VGA_CLK are registered.
  - They are computed from the next counter values, so on every edge they are coherent with h_cnt/v_cnt. There is zero pixel latency between counters and outputs.
- Signal decode:
  - VGA_HS = HS_POL while h_cnt < H_SYNC, otherwise ~HS_POL. VGA_VS is decoded the same way from v_cnt, V_SYNC and VS_POL.
  - ativo_vga = (HA0 <= h_cnt < HA0+H_ACTIVE) && (VA0 <= v_cnt < VA0+V_ACTIVE).
  - VGA_BLANK_N = ativo_vga.
  - x = h_cnt-HA0 inside the horizontal active window, otherwise 0. y = v_cnt-VA0 inside the vertical active window, otherwise 0.
- Strobes and frame counter:
  - line_start pulses for the single CLOCK_50 cycle after the edge where h_cnt becomes 0.
  - frame_start pulses in that same cycle, and only when v_cnt also becomes 0.
  - frame_cnt increments with each frame_start and wraps modulo 2^FRAME_W.
- Reset values:
  - div_cnt = 0, h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
  - ativo_vga = 0, VGA_BLANK_N = 0, x = 0, y = 0.
  - pix_en, line_start and frame_start = 0; frame_cnt = 0.
  - Consequence: the first pix_en after reset wraps both counters to 0, so frame_start fires and frame_cnt becomes 1.
- Reset asserted mid-line or mid-frame returns all state to the reset values immediately, without waiting for a clock edge.
- Counter widths are sized by clog2 of the totals. No counter may overflow past its total under any parameter set.

Test Plan:
- Defaults, release reset with enable=1 → pix_en every 2nd cycle; the first pix_en gives h=0, v=0, frame_start=1, frame_cnt=1, VGA_HS=0, VGA_VS=0.
- Defaults, full line → VGA_HS low for exactly 96 pixels. ativo_vga first rises at h=144 with x=0 and falls after x=639. line_start pulses every 800 pixels.
- Defaults, full frame → VGA_VS low for exactly 2 lines. y runs 0..479 over lines 35..514. frame_start recurs every 800*525 = 420000 pixels. frame_cnt increments by 1.
- Small parameters, e.g. 8/1/2/1 horizontal and 4/1/1/1 vertical, with HS_POL=1, VS_POL=1, CLK_DIV=4 → sync pulses are high. H_TOTAL is 12 and V_TOTAL is 7. VGA_CLK is 2 cycles low then 2 high. frame_cnt wraps from 0xFFFF to 0 after the required number of frames.
- Drop enable mid-active at x=100 for 37 cycles → all outputs frozen with no strobes. x resumes at 101 on the next pix_en after enable returns.
- Assert reset asynchronously between clock edges mid-frame → outputs reach the reset values before the next edge. On release, the first pix_en behaves as in the first scenario.
